instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL use one clock, CLK; reset is synchronous and active-high, RESET.
REQ-002 SHALL have ports (name  direction  width  meaning):
- CLK  in  1  clock, rising edge.
- RESET  in  1  synchronous active-high reset.
- imem_read  out  1  instruction memory read request.
- imem_addr  out  32  byte address of the fetch, equal to PC.
- imem_readdata  in  32  instruction word, valid when imem_busywait=0.
- imem_busywait  in  1  memory not ready.
- instr_valid  out  1  one-cycle pulse; issued fields are valid.
- opcode  out  8  IR[31:24], to the control unit.
- rd_off  out  8  IR[23:16]; destination register, or jump/beq word offset.
- rs  out  8  IR[15:8].
- rt_imm  out  8  IR[7:0]; source register or immediate.
- jump  in  1  from the control unit, sampled in ISSUE.
- branch  in  1  from the control unit, sampled in ISSUE.
- zero  in  1  ALU zero flag, sampled in ISSUE.
- pc  out  32  current PC.
- halted  out  1  illegal-opcode halt; see REQ-016.

Function
REQ-003 SHALL implement FSM states FETCH, ISSUE and HALT.
REQ-004 FETCH: imem_read=1, imem_addr=pc; on a rising edge with imem_busywait=0, IR<=imem_readdata and go to ISSUE; otherwise stay in FETCH.
REQ-005 Minimum fetch latency SHALL be one cycle; each busywait cycle adds one.
REQ-006 ISSUE: imem_read=0, instr_valid=1 for exactly one cycle; opcode, rd_off, rs and rt_imm are driven from IR and held until the next IR load.
REQ-007 On the ISSUE edge, pc SHALL update and the FSM returns to FETCH.
REQ-008 Next PC:
- jump=1 -> pc+4+(sext(rd_off)<<2)
- else branch&zero -> the same target
- else pc+4
REQ-009 jump SHALL take priority when jump and branch are both 1; branch with zero=0 SHALL yield pc+4.
REQ-010 PC arithmetic SHALL be 32-bit modulo; 0xFFFFFFFC+4 wraps to 0.
REQ-011 A negative offset (e.g. 0xFE) SHALL yield pc+4-8.
REQ-012 Issue throughput SHALL be at most one instruction per two cycles; there is no pipelining or prefetch.
REQ-013 jump, branch and zero SHALL be ignored outside ISSUE.

Reset
REQ-014 On RESET=1 at an edge:
- pc=0, IR=0, state=FETCH.
- instr_valid=0, opcode/rd_off/rs/rt_imm=0, halted=0.
- imem_read=0 for that cycle.
REQ-015 RESET SHALL override any state, including mid-fetch with busywait=1 and HALT; the fetch at address 0 starts on the first cycle after RESET deasserts.

Configuration
REQ-016 Macro IFU_ILLEGAL_TRAP_EN:
- Defined: an ISSUE with opcode>0x07 SHALL still pulse instr_valid, SHALL leave pc unchanged, and SHALL enter HALT. In HALT: halted=1, imem_read=0, instr_valid=0, exit only via RESET.
- Undefined: there is no HALT state, halted is tied to 0, and an unknown opcode advances pc by 4 like a no-op.

Structure
REQ-017 Shared package cpu_pkg SHALL hold:
- opcode constants OP_LOADI=0x00, OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_J, OP_BEQ=0x07
- ALU op encodings
- FSM state enum
- widths PC_W=32, INSTR_W=32
REQ-018 Next-PC computation SHALL live in one combinational sub-module, pc_next; there are no other sub-modules.

Verification
REQ-019 The bench SHALL cover:
- Reset then busywait=0: imem_addr=0 in cycle 1; instr_valid in cycle 2; pc=4 after it.
- Busywait held 3 cycles on 0x02040102: imem_read stays 1 for 4 cycles; then instr_valid=1 with opcode=0x02, rd_off=0x04, rs=0x01, rt_imm=0x02.
- pc=0x10, jump=1, rd_off=0xFE: next imem_addr=0x0C. With branch=1, zero=0, rd_off=0x03: next=0x14. With zero=1: next=0x20.
- RESET during busywait at pc=0x40: the next cycle has imem_read=0, pc=0; the fetch restarts at 0.
- Opcode 0x09 with the macro defined: halted=1, pc unchanged, no further imem_read. Without the macro: pc advances by 4.
- pc=0xFFFFFFFC with a no-op: the next fetch is at 0x00000000.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: widths, opcodes, ALU encodings and fetch FSM states.
package cpu_pkg;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;

  typedef enum logic [2:0] {
    ALU_FWD = 3'd0,
    ALU_ADD = 3'd1,
    ALU_SUB = 3'd2,
    ALU_AND = 3'd3,
    ALU_OR  = 3'd4
  } alu_op_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    HALT  = 2'd2
  } ifu_state_t;

  // Anything above the highest defined opcode is treated as illegal.
  function automatic logic is_legal(input logic [7:0] op);
    return op <= OP_BEQ;
  endfunction

endpackage

// File: rtl/pc_next.sv
// Combinational next-PC selection: jump, taken branch, or sequential pc+4.
module pc_next
  import cpu_pkg::*;
(
  input  logic [PC_W-1:0] pc,
  input  logic [7:0]      offset,
  input  logic            jump,
  input  logic            branch,
  input  logic            zero,
  output logic [PC_W-1:0] next_pc
);

  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] target;

  // Offset counts words relative to the following instruction; wraps modulo 2^32.
  assign pc_plus4 = pc + 32'd4;
  assign target   = pc_plus4 + {{(PC_W-10){offset[7]}}, offset, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump)
      next_pc = target;
    else if (branch && zero)
      next_pc = target;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Non-pipelined instruction fetch/issue unit with registered FSM outputs.
// Optional illegal-opcode halt is enabled by defining IFU_ILLEGAL_TRAP_EN.
module instr_fetch_unit
  import cpu_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  output logic               imem_read,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_readdata,
  input  logic               imem_busywait,
  output logic               instr_valid,
  output logic [7:0]         opcode,
  output logic [7:0]         rd_off,
  output logic [7:0]         rs,
  output logic [7:0]         rt_imm,
  input  logic               jump,
  input  logic               branch,
  input  logic               zero,
  output logic [PC_W-1:0]    pc,
  output logic               halted
);

  ifu_state_t         state;
  logic [INSTR_W-1:0] ir;
  logic [PC_W-1:0]    next_pc;

  assign imem_addr = pc;
  assign opcode    = ir[31:24];
  assign rd_off    = ir[23:16];
  assign rs        = ir[15:8];
  assign rt_imm    = ir[7:0];

  pc_next u_pc_next (
    .pc      (pc),
    .offset  (rd_off),
    .jump    (jump),
    .branch  (branch),
    .zero    (zero),
    .next_pc (next_pc)
  );

`ifndef IFU_ILLEGAL_TRAP_EN
  assign halted = 1'b0;
`endif

  // The first FETCH cycle after reset has imem_read low; it only raises the
  // request, so busywait is never trusted before a read is actually issued.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= FETCH;
      pc          <= '0;
      ir          <= '0;
      imem_read   <= 1'b0;
      instr_valid <= 1'b0;
`ifdef IFU_ILLEGAL_TRAP_EN
      halted      <= 1'b0;
`endif
    end else begin
      case (state)
        FETCH: begin
          if (!imem_read) begin
            imem_read <= 1'b1;
          end else if (!imem_busywait) begin
            ir          <= imem_readdata;
            imem_read   <= 1'b0;
            instr_valid <= 1'b1;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          instr_valid <= 1'b0;
`ifdef IFU_ILLEGAL_TRAP_EN
          if (!is_legal(opcode)) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            pc        <= next_pc;
            imem_read <= 1'b1;
            state     <= FETCH;
          end
`else
          pc        <= next_pc;
          imem_read <= 1'b1;
          state     <= FETCH;
`endif
        end
        default: begin
          imem_read   <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected fetches/issues are queued by
// the stimulus and popped by an independent monitor.
module tb_instr_fetch_unit;

  logic        CLK;
  logic        RESET;
  logic        imem_read;
  logic [31:0] imem_addr;
  logic [31:0] imem_readdata;
  logic        imem_busywait;
  logic        instr_valid;
  logic [7:0]  opcode;
  logic [7:0]  rd_off;
  logic [7:0]  rs;
  logic [7:0]  rt_imm;
  logic        jump;
  logic        branch;
  logic        zero;
  logic [31:0] pc;
  logic        halted;

  typedef struct {
    logic [7:0]  op;
    logic [7:0]  rd;
    logic [7:0]  rs;
    logic [7:0]  rt;
    logic [31:0] pc;
  } issue_t;

  typedef struct {
    logic [31:0] word;
    int          wait_n;
  } mem_t;

  typedef struct {
    logic j;
    logic b;
    logic z;
  } ctrl_t;

  issue_t      issue_q[$];
  mem_t        mem_q[$];
  ctrl_t       ctrl_q[$];
  logic [31:0] addr_q[$];

  int n_compared   = 0;
  int n_mismatched = 0;

  instr_fetch_unit dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .imem_read     (imem_read),
    .imem_addr     (imem_addr),
    .imem_readdata (imem_readdata),
    .imem_busywait (imem_busywait),
    .instr_valid   (instr_valid),
    .opcode        (opcode),
    .rd_off        (rd_off),
    .rs            (rs),
    .rt_imm        (rt_imm),
    .jump          (jump),
    .branch        (branch),
    .zero          (zero),
    .pc            (pc),
    .halted        (halted)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_fetch(input logic [31:0] addr, input logic [31:0] word, input int wait_n);
    mem_t m;
    m.word   = word;
    m.wait_n = wait_n;
    addr_q.push_back(addr);
    mem_q.push_back(m);
  endtask

  task automatic push_issue(input logic [31:0] addr, input logic [31:0] word,
                            input logic j, input logic b, input logic z);
    issue_t e;
    ctrl_t  c;
    e.op = word[31:24];
    e.rd = word[23:16];
    e.rs = word[15:8];
    e.rt = word[7:0];
    e.pc = addr;
    c.j  = j;
    c.b  = b;
    c.z  = z;
    issue_q.push_back(e);
    ctrl_q.push_back(c);
  endtask

  task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] word, input int wait_n,
                                input logic j, input logic b, input logic z);
    push_fetch(addr, word, wait_n);
    push_issue(addr, word, j, b, z);
  endtask

  task automatic wait_issues(input int max_cycles);
    int n;
    n = 0;
    while (issue_q.size() != 0 && n < max_cycles) begin
      @(negedge CLK);
      n++;
    end
    check_output("issue_drain_timeout", 32'(issue_q.size() != 0), 32'd0);
  endtask

  // Memory model: each new read request consumes one queued word and stalls
  // for its wait count before returning data.
  initial begin : mem_model
    int   cnt;
    bit   in_fetch;
    mem_t cur;
    cnt      = 0;
    in_fetch = 1'b0;
    cur.word = '0;
    forever begin
      @(negedge CLK);
      if (imem_read) begin
        if (!in_fetch) begin
          in_fetch = 1'b1;
          if (mem_q.size() > 0) begin
            cur = mem_q.pop_front();
            cnt = cur.wait_n;
          end else begin
            cur.word = '0;
            cnt      = 1000000;
          end
        end
        if (cnt > 0) begin
          imem_busywait = 1'b1;
          imem_readdata = $urandom;
          cnt--;
        end else begin
          imem_busywait = 1'b0;
          imem_readdata = cur.word;
        end
      end else begin
        in_fetch      = 1'b0;
        imem_busywait = 1'($urandom_range(0, 1));
        imem_readdata = $urandom;
      end
    end
  end

  // Control model: real decisions during ISSUE, noise at all other times.
  initial begin : ctrl_model
    ctrl_t c;
    forever begin
      @(negedge CLK);
      if (instr_valid) begin
        if (ctrl_q.size() > 0) c = ctrl_q.pop_front();
        else begin
          c.j = 1'b0; c.b = 1'b0; c.z = 1'b0;
        end
        jump   = c.j;
        branch = c.b;
        zero   = c.z;
      end else begin
        jump   = 1'($urandom_range(0, 1));
        branch = 1'($urandom_range(0, 1));
        zero   = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: compares every new fetch address and every issued instruction.
  initial begin : monitor
    logic   prev_read;
    issue_t e;
    prev_read = 1'b0;
    forever begin
      @(negedge CLK);
      if (imem_read && !prev_read) begin
        if (addr_q.size() == 0)
          check_output("unexpected_fetch", imem_addr, 32'hDEAD_BEEF);
        else
          check_output("fetch_addr", imem_addr, addr_q.pop_front());
      end
      prev_read = imem_read;
      if (instr_valid) begin
        if (issue_q.size() == 0) begin
          check_output("unexpected_issue", {24'd0, opcode}, 32'hDEAD_BEEF);
        end else begin
          e = issue_q.pop_front();
          check_output("issue_opcode", {24'd0, opcode}, {24'd0, e.op});
          check_output("issue_rd_off", {24'd0, rd_off}, {24'd0, e.rd});
          check_output("issue_rs",     {24'd0, rs},     {24'd0, e.rs});
          check_output("issue_rt_imm", {24'd0, rt_imm}, {24'd0, e.rt});
          check_output("issue_pc",     pc,              e.pc);
          check_output("issue_read_low", {31'd0, imem_read}, 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int cnt;
    int n;
    RESET         = 1'b1;
    imem_readdata = '0;
    imem_busywait = 1'b0;
    jump          = 1'b0;
    branch        = 1'b0;
    zero          = 1'b0;

    apply_stimulus(32'h0000_0000, 32'h0001_0203, 0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(32'h0000_0004, 32'h0204_0102, 3, 1'b0, 1'b0, 1'b0);
    apply_stimulus(32'h0000_0008, 32'h0601_0000, 0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(32'h0000_0010, 32'h06FE_0000, 0, 1'b1, 1'b1, 1'b0);
    apply_stimulus(32'h0000_000C, 32'h0700_0000, 0, 1'b0, 1'b1, 1'b1);
    apply_stimulus(32'h0000_0010, 32'h0703_0000, 1, 1'b0, 1'b1, 1'b0);
    apply_stimulus(32'h0000_0014, 32'h06FE_0000, 0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(32'h0000_0010, 32'h0703_0000, 0, 1'b0, 1'b1, 1'b1);
    apply_stimulus(32'h0000_0020, 32'h0500_0807, 0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(32'h0000_0024, 32'h06F5_0000, 0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(32'hFFFF_FFFC, 32'h0100_0000, 0, 1'b0, 1'b0, 1'b0);
    apply_stimulus(32'h0000_0000, 32'h060F_0000, 0, 1'b1, 1'b0, 1'b0);
    push_fetch(32'h0000_0040, 32'h0000_0000, 200);

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_output("reset_pc",          pc,                  32'd0);
    check_output("reset_imem_read",   {31'd0, imem_read},  32'd0);
    check_output("reset_instr_valid", {31'd0, instr_valid}, 32'd0);
    check_output("reset_opcode",      {24'd0, opcode},     32'd0);
    check_output("reset_rd_off",      {24'd0, rd_off},     32'd0);
    check_output("reset_rs",          {24'd0, rs},         32'd0);
    check_output("reset_rt_imm",      {24'd0, rt_imm},     32'd0);
    check_output("reset_halted",      {31'd0, halted},     32'd0);
    RESET = 1'b0;

    @(negedge CLK);
    check_output("cycle1_read", {31'd0, imem_read}, 32'd1);
    check_output("cycle1_addr", imem_addr,          32'd0);
    @(negedge CLK);
    check_output("cycle2_valid", {31'd0, instr_valid}, 32'd1);
    @(negedge CLK);
    check_output("pc_after_first", pc, 32'd4);

    cnt = 0;
    while (imem_read && cnt < 20) begin
      cnt++;
      @(negedge CLK);
    end
    check_output("busywait_read_cycles", 32'(cnt), 32'd4);

    n = 0;
    while (!(imem_read && imem_addr == 32'h40) && n < 300) begin
      @(negedge CLK);
      n++;
    end
    check_output("reach_0x40_timeout", 32'(n >= 300), 32'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check_output("midfetch_reset_read",   {31'd0, imem_read},   32'd0);
    check_output("midfetch_reset_pc",     pc,                   32'd0);
    check_output("midfetch_reset_valid",  {31'd0, instr_valid}, 32'd0);
    check_output("midfetch_reset_opcode", {24'd0, opcode},      32'd0);

    apply_stimulus(32'h0000_0000, 32'h0900_0000, 0, 1'b0, 1'b0, 1'b0);
`ifndef IFU_ILLEGAL_TRAP_EN
    push_fetch(32'h0000_0004, 32'h0000_0000, 200);
`endif
    RESET = 1'b0;
    @(negedge CLK);
    check_output("restart_read", {31'd0, imem_read}, 32'd1);
    check_output("restart_addr", imem_addr,          32'd0);
    wait_issues(20);
    @(negedge CLK);
`ifdef IFU_ILLEGAL_TRAP_EN
    check_output("illegal_halted", {31'd0, halted}, 32'd1);
    check_output("illegal_pc",     pc,              32'd0);
    cnt = 0;
    repeat (5) begin
      @(negedge CLK);
      if (imem_read || instr_valid) cnt++;
    end
    check_output("halt_no_activity", 32'(cnt), 32'd0);
`else
    check_output("illegal_halted", {31'd0, halted}, 32'd0);
    check_output("illegal_pc",     pc,              32'd4);
`endif

    RESET = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    check_output("final_reset_halted", {31'd0, halted}, 32'd0);
    check_output("final_reset_pc",     pc,              32'd0);
    apply_stimulus(32'h0000_0000, 32'h0311_2233, 1, 1'b0, 1'b1, 1'b1);
    push_fetch(32'h0000_0048, 32'h0000_0000, 200);
    RESET = 1'b0;
    wait_issues(30);
    @(negedge CLK);
    check_output("final_branch_pc", pc, 32'h48);
    repeat (2) @(negedge CLK);
    check_output("fetch_queue_empty", 32'(addr_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
